// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared constants for the writeback stage: opcode and ALU-op encodings that
// the stage decodes, the rstatus codes it writes on overflow / multdiv
// exception, the pipeline write-source selector, and a helper that maps an
// instruction to its overflow code.
// ----------------------------------------------------------------------------
package wb_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_SETX  = 5'b10101;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;

   localparam logic [2:0] RS_ADD_OVF  = 3'd1;
   localparam logic [2:0] RS_ADDI_OVF = 3'd2;
   localparam logic [2:0] RS_SUB_OVF  = 3'd3;
   localparam logic [2:0] RS_MUL_EXC  = 3'd4;
   localparam logic [2:0] RS_DIV_EXC  = 3'd5;

   typedef enum logic [2:0] {
      SRC_ALU,
      SRC_LOAD,
      SRC_JAL,
      SRC_SETX,
      SRC_OVF
   } wb_src_e;

   // Returns the rstatus code for an overflow-class instruction, 0 otherwise.
   function automatic logic [2:0] ovf_code(input logic [4:0] opcode,
                                           input logic [4:0] aluop);
      logic [2:0] code;
      code = 3'd0;
      if (opcode == OP_ADDI) begin
         code = RS_ADDI_OVF;
      end else if (opcode == OP_RTYPE) begin
         if (aluop == ALU_ADD) code = RS_ADD_OVF;
         else if (aluop == ALU_SUB) code = RS_SUB_OVF;
      end
      return code;
   endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// ----------------------------------------------------------------------------
// wb_pend_fifo
// Circular buffer of pending multdiv results {valid, rd, data}. An entry whose
// valid bit has been cleared by a squash keeps its slot; it is discarded when
// it is popped from the head.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   push_i, push_rd_i,   enqueue request and payload (ignored when full)
//   push_data_i
//   pop_i                dequeue head (ignored when empty)
//   squash_i, squash_rd_i  invalidate every stored entry targeting squash_rd_i
//   full_o, empty_o      occupancy flags from registered state
//   count_o              occupancy
//   head_valid_o, head_rd_o, head_data_o  head entry (valid only if not empty)
// ----------------------------------------------------------------------------
module wb_pend_fifo #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push_i,
   input  logic [AW-1:0] push_rd_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   input  logic          squash_i,
   input  logic [AW-1:0] squash_rd_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o,
   output logic          head_valid_o,
   output logic [AW-1:0] head_rd_o,
   output logic [DW-1:0] head_data_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] vld_q;
   logic [AW-1:0]    rd_q   [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [PW-1:0]    rptr_q, wptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   assign head_valid_o = ~empty_o & vld_q[rptr_q];
   assign head_rd_o    = rd_q[rptr_q];
   assign head_data_o  = data_q[rptr_q];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q  <= '0;
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         // Free slots always hold vld=0, so squash can scan every slot.
         for (int i = 0; i < DEPTH; i++) begin
            if (squash_i && vld_q[i] && (rd_q[i] == squash_rd_i)) vld_q[i] <= 1'b0;
         end
         if (do_pop) begin
            vld_q[rptr_q] <= 1'b0;
            rptr_q        <= ptr_inc(rptr_q);
         end
         // The push slot is free, so it never collides with a squash or pop.
         if (do_push) begin
            vld_q[wptr_q] <= 1'b1;
            wptr_q        <= ptr_inc(wptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Payload storage needs no reset; vld_q qualifies it.
   always_ff @(posedge clock) begin
      if (do_push) begin
         rd_q[wptr_q]   <= push_rd_i;
         data_q[wptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/writeback_unit.sv
// ----------------------------------------------------------------------------
// writeback_unit
// Registered writeback stage. Selects the main pipeline's register write
// (load data, ALU result, jal link, setx target or rstatus overflow code),
// buffers multdiv results in a small pending FIFO, and presents at most one
// register-file write per cycle with one cycle of latency. The pipeline has
// priority; the FIFO drains on cycles without a pipeline write. A pipeline
// write squashes older buffered results to the same register.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   mw_*                    MEM/WB instruction fields
//   md_valid/md_ready       multdiv result handshake
//   md_is_div, md_exc,      multdiv result payload
//   md_rd, md_result
//   wb_we, wb_rd, wb_data   registered register-file write port
//   pend_count              pending-buffer occupancy
// ----------------------------------------------------------------------------
module writeback_unit
   import wb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int OP_W        = 5,
   parameter int PEND_DEPTH  = 2,
   parameter int RSTATUS_REG = 30,
   parameter int RA_REG      = 31
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        mw_valid,
   input  logic                        mw_we,
   input  logic                        mw_load,
   input  logic [OP_W-1:0]             mw_opcode,
   input  logic [OP_W-1:0]             mw_aluop,
   input  logic                        mw_ovf,
   input  logic [REG_AW-1:0]           mw_rd,
   input  logic [DATA_W-1:0]           mw_alu_out,
   input  logic [DATA_W-1:0]           mw_dmem_q,
   input  logic [DATA_W-1:0]           mw_pc_next,
   input  logic [DATA_W-1:0]           mw_target,
   input  logic                        md_valid,
   output logic                        md_ready,
   input  logic                        md_is_div,
   input  logic                        md_exc,
   input  logic [REG_AW-1:0]           md_rd,
   input  logic [DATA_W-1:0]           md_result,
   output logic                        wb_we,
   output logic [REG_AW-1:0]           wb_rd,
   output logic [DATA_W-1:0]           wb_data,
   output logic [$clog2(PEND_DEPTH):0] pend_count
);

   localparam int CW = $clog2(PEND_DEPTH) + 1;

   wb_src_e           src;
   logic [2:0]        code;
   logic              is_setx, is_jal;
   logic [REG_AW-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic              pipe_wr;

   logic              md_push;
   logic [REG_AW-1:0] md_push_rd;
   logic [DATA_W-1:0] md_push_data;
   logic              fifo_full, fifo_empty;
   logic              head_valid;
   logic [REG_AW-1:0] head_rd;
   logic [DATA_W-1:0] head_data;

   // ---- pipeline write selection (priority order) ----
   assign code    = ovf_code(mw_opcode, mw_aluop);
   assign is_setx = (mw_opcode == OP_SETX);
   assign is_jal  = (mw_opcode == OP_JAL);

   always_comb begin
      src = SRC_ALU;
      if (is_setx)                       src = SRC_SETX;
      else if ((code != 3'd0) && mw_ovf) src = SRC_OVF;
      else if (is_jal && mw_we)          src = SRC_JAL;
      else if (mw_load)                  src = SRC_LOAD;
   end

   always_comb begin
      sel_rd   = mw_rd;
      sel_data = mw_alu_out;
      case (src)
         SRC_SETX: begin
            sel_rd   = REG_AW'(RSTATUS_REG);
            sel_data = mw_target;
         end
         SRC_OVF: begin
            sel_rd   = REG_AW'(RSTATUS_REG);
            sel_data = {{(DATA_W-3){1'b0}}, code};
         end
         SRC_JAL: begin
            sel_rd   = REG_AW'(RA_REG);
            sel_data = mw_pc_next;
         end
         SRC_LOAD: sel_data = mw_dmem_q;
         default:  sel_data = mw_alu_out;
      endcase
   end

   // setx writes rstatus even when the decoder left mw_we low.
   assign pipe_wr = mw_valid & (mw_we | is_setx) & (sel_rd != '0);

   // ---- multdiv enqueue ----
   // Exceptions are rewritten to an rstatus write; r0 results are accepted
   // by the handshake but never stored.
   assign md_ready     = ~fifo_full;
   assign md_push      = md_valid & md_ready & (md_exc | (md_rd != '0));
   assign md_push_rd   = md_exc ? REG_AW'(RSTATUS_REG) : md_rd;
   assign md_push_data = md_exc ? {{(DATA_W-3){1'b0}}, (md_is_div ? RS_DIV_EXC : RS_MUL_EXC)}
                                : md_result;

   wb_pend_fifo #(
      .DEPTH (PEND_DEPTH),
      .AW    (REG_AW),
      .DW    (DATA_W),
      .CW    (CW)
   ) u_pend (
      .clock        (clock),
      .reset        (reset),
      .push_i       (md_push),
      .push_rd_i    (md_push_rd),
      .push_data_i  (md_push_data),
      .pop_i        (~pipe_wr),
      .squash_i     (pipe_wr),
      .squash_rd_i  (sel_rd),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .count_o      (pend_count),
      .head_valid_o (head_valid),
      .head_rd_o    (head_rd),
      .head_data_o  (head_data)
   );

   // ---- registered write port ----
   // A squashed head still pops, but produces no write that cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_we   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else if (pipe_wr) begin
         wb_we   <= 1'b1;
         wb_rd   <= sel_rd;
         wb_data <= sel_data;
      end else if (!fifo_empty && head_valid) begin
         wb_we   <= 1'b1;
         wb_rd   <= head_rd;
         wb_data <= head_data;
      end else begin
         wb_we   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        mw_valid, mw_we, mw_load, mw_ovf;
   logic [4:0]  mw_opcode, mw_aluop, mw_rd;
   logic [31:0] mw_alu_out, mw_dmem_q, mw_pc_next, mw_target;
   logic        md_valid, md_ready, md_is_div, md_exc;
   logic [4:0]  md_rd;
   logic [31:0] md_result;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [1:0]  pend_count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [4:0]  last_rd;
   logic [31:0] last_data;

   writeback_unit dut (
      .clock      (clock),
      .reset      (reset),
      .mw_valid   (mw_valid),
      .mw_we      (mw_we),
      .mw_load    (mw_load),
      .mw_opcode  (mw_opcode),
      .mw_aluop   (mw_aluop),
      .mw_ovf     (mw_ovf),
      .mw_rd      (mw_rd),
      .mw_alu_out (mw_alu_out),
      .mw_dmem_q  (mw_dmem_q),
      .mw_pc_next (mw_pc_next),
      .mw_target  (mw_target),
      .md_valid   (md_valid),
      .md_ready   (md_ready),
      .md_is_div  (md_is_div),
      .md_exc     (md_exc),
      .md_rd      (md_rd),
      .md_result  (md_result),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .pend_count (pend_count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected run to finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pipe_idle();
      mw_valid = 0; mw_we = 0; mw_load = 0; mw_ovf = 0;
      mw_opcode = 5'b00000; mw_aluop = 5'b00010; mw_rd = 0;
      mw_alu_out = 0; mw_dmem_q = 0; mw_pc_next = 0; mw_target = 0;
   endtask

   task automatic pipe_alu(input logic [4:0] rd, input logic [31:0] d);
      pipe_idle();
      mw_valid = 1; mw_we = 1; mw_rd = rd; mw_alu_out = d;
   endtask

   task automatic md_idle();
      md_valid = 0; md_is_div = 0; md_exc = 0; md_rd = 0; md_result = 0;
   endtask

   task automatic md_offer(input logic [4:0] rd, input logic [31:0] d,
                           input logic is_div, input logic exc);
      md_valid = 1; md_rd = rd; md_result = d; md_is_div = is_div; md_exc = exc;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      e.we = 1'b1; e.rd = rd; e.data = d;
      sb.push_back(e);
      last_rd = rd; last_data = d;
   endtask

   task automatic expect_idle();
      exp_t e;
      e.we = 1'b0; e.rd = last_rd; e.data = last_data;
      sb.push_back(e);
   endtask

   // One clock: outputs registered from the inputs driven before the call are
   // compared against the oldest scoreboard entry.
   task automatic cycle(input string tag);
      exp_t e;
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         chk({tag, "_sb"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_we"},   {31'd0, wb_we}, {31'd0, e.we});
         chk({tag, "_rd"},   {27'd0, wb_rd}, {27'd0, e.rd});
         chk({tag, "_data"}, wb_data,        e.data);
      end
   endtask

   initial begin
      reset = 1;
      pipe_idle();
      md_idle();
      last_rd = 0; last_data = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 0;
      chk("rst_we",    {31'd0, wb_we}, 32'd0);
      chk("rst_rd",    {27'd0, wb_rd}, 32'd0);
      chk("rst_data",  wb_data, 32'd0);
      chk("rst_pend",  {30'd0, pend_count}, 32'd0);
      chk("rst_ready", {31'd0, md_ready}, 32'd1);

      // overflow codes
      pipe_alu(5, 32'h1111); mw_aluop = 5'b00000; mw_ovf = 1;
      expect_wr(30, 1); cycle("add_ovf");
      pipe_alu(5, 32'h1111); mw_aluop = 5'b00001; mw_ovf = 1;
      expect_wr(30, 3); cycle("sub_ovf");
      pipe_alu(6, 32'h2222); mw_opcode = 5'b00101; mw_ovf = 1;
      expect_wr(30, 2); cycle("addi_ovf");
      pipe_alu(4, 32'h77); mw_aluop = 5'b00000; mw_ovf = 0;
      expect_wr(4, 32'h77); cycle("add_noovf");

      // setx, jal, load
      pipe_idle(); mw_valid = 1; mw_opcode = 5'b10101; mw_target = 32'h0001234; mw_rd = 3;
      expect_wr(30, 32'h00001234); cycle("setx");
      pipe_alu(3, 32'h99); mw_opcode = 5'b00011; mw_pc_next = 32'h40;
      expect_wr(31, 32'h40); cycle("jal");
      pipe_alu(6, 32'h99); mw_opcode = 5'b01000; mw_load = 1; mw_dmem_q = 32'hCAFE;
      expect_wr(6, 32'hCAFE); cycle("lw");
      pipe_alu(5, 32'h55); mw_valid = 0;
      expect_idle(); cycle("not_valid");

      // md result behind three pipeline writes
      pipe_alu(1, 32'h11); md_offer(7, 32'hDEAD, 0, 0);
      expect_wr(1, 32'h11); cycle("bb1");
      chk("bb1_pend", {30'd0, pend_count}, 32'd1);
      md_idle();
      pipe_alu(2, 32'h22); expect_wr(2, 32'h22); cycle("bb2");
      chk("bb2_pend", {30'd0, pend_count}, 32'd1);
      pipe_alu(3, 32'h33); expect_wr(3, 32'h33); cycle("bb3");
      chk("bb3_pend", {30'd0, pend_count}, 32'd1);
      pipe_idle(); expect_wr(7, 32'hDEAD); cycle("bb_drain");
      chk("bb_pend0", {30'd0, pend_count}, 32'd0);

      // fill, offer while full (ignored), then drain
      pipe_alu(1, 32'h101); md_offer(10, 32'hA0A0, 0, 0);
      expect_wr(1, 32'h101); cycle("fill1");
      pipe_alu(2, 32'h102); md_offer(11, 32'hB0B0, 1, 0);
      expect_wr(2, 32'h102); cycle("fill2");
      chk("full_ready", {31'd0, md_ready}, 32'd0);
      chk("full_pend", {30'd0, pend_count}, 32'd2);
      pipe_alu(3, 32'h103); md_offer(12, 32'hC0C0, 0, 0);
      expect_wr(3, 32'h103); cycle("fill3");
      chk("full_pend2", {30'd0, pend_count}, 32'd2);
      md_idle(); pipe_idle();
      expect_wr(10, 32'hA0A0); cycle("drain1");
      chk("drain_ready", {31'd0, md_ready}, 32'd1);
      chk("drain_pend", {30'd0, pend_count}, 32'd1);
      expect_wr(11, 32'hB0B0); cycle("drain2");
      expect_idle(); cycle("drain3");

      // WAW squash
      md_offer(9, 32'hBEEF, 0, 0);
      expect_idle(); cycle("sq_enq");
      md_idle();
      pipe_alu(9, 32'h0); mw_load = 1; mw_opcode = 5'b01000; mw_dmem_q = 32'h9999;
      expect_wr(9, 32'h9999); cycle("sq_lw");
      chk("sq_pend1", {30'd0, pend_count}, 32'd1);
      pipe_idle(); expect_idle(); cycle("sq_discard");
      chk("sq_pend0", {30'd0, pend_count}, 32'd0);
      expect_idle(); cycle("sq_after");

      // multdiv exceptions
      md_offer(8, 32'h1234, 1, 1); expect_idle(); cycle("div_enq");
      md_offer(0, 32'h5678, 0, 1); expect_wr(30, 5); cycle("div_exc");
      md_idle(); expect_wr(30, 4); cycle("mul_exc");

      // r0 writes
      pipe_alu(0, 32'hFFFF); expect_idle(); cycle("r0_pipe");
      pipe_idle(); md_offer(0, 32'hEEEE, 0, 0); expect_idle(); cycle("r0_md");
      chk("r0_pend", {30'd0, pend_count}, 32'd0);
      md_idle(); expect_idle(); cycle("r0_after");

      // simultaneous enqueue and pop
      md_offer(13, 32'h1313, 0, 0); expect_idle(); cycle("ep_enq");
      md_offer(14, 32'h1414, 0, 0); expect_wr(13, 32'h1313); cycle("ep_both");
      chk("ep_pend", {30'd0, pend_count}, 32'd1);
      md_idle(); expect_wr(14, 32'h1414); cycle("ep_drain");

      // reset with two entries queued
      pipe_alu(1, 32'h201); md_offer(15, 32'h1515, 0, 0);
      expect_wr(1, 32'h201); cycle("rq1");
      pipe_alu(2, 32'h202); md_offer(16, 32'h1616, 0, 0);
      expect_wr(2, 32'h202); cycle("rq2");
      chk("rq_pend2", {30'd0, pend_count}, 32'd2);
      md_idle(); pipe_alu(3, 32'h203); reset = 1;
      last_rd = 0; last_data = 0;
      expect_idle(); cycle("rq_reset");
      chk("rq_pend0", {30'd0, pend_count}, 32'd0);
      chk("rq_ready", {31'd0, md_ready}, 32'd1);
      reset = 0; pipe_idle();
      expect_idle(); cycle("rq_lost1");
      expect_idle(); cycle("rq_lost2");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Registered, parametrised writeback stage for the pipelined processor. Sits between the MEM/WB boundary and the register file write port.
- Selects the write data and destination for the main pipeline: load data, ALU result, jal link, setx target, or an rstatus overflow code.
- Merges results from the multi-cycle multdiv unit through a small pending buffer. Only one register-file write is presented per cycle.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- OP_W, 5, opcode / ALU-op width
- PEND_DEPTH, 2, multdiv pending-buffer entries (power of 2, >=2)
- RSTATUS_REG, 30, status register index
- RA_REG, 31, link register index

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mw_valid  in  1  MEM/WB slot holds a live instruction
- mw_we  in  1  instruction writes a register
- mw_load  in  1  instruction is lw
- mw_opcode  in  OP_W  instruction opcode
- mw_aluop  in  OP_W  R-type ALU op
- mw_ovf  in  1  ALU overflow flag
- mw_rd  in  REG_AW  destination register
- mw_alu_out  in  DATA_W  ALU result
- mw_dmem_q  in  DATA_W  load data
- mw_pc_next  in  DATA_W  PC+1 for jal
- mw_target  in  DATA_W  zero-extended setx target
- md_valid  in  1  multdiv result offered
- md_ready  out  1  pending buffer can accept a result
- md_is_div  in  1  result is from div (else mul)
- md_exc  in  1  multdiv exception
- md_rd  in  REG_AW  multdiv destination
- md_result  in  DATA_W  multdiv result
- wb_we  out  1  register-file write enable (registered)
- wb_rd  out  REG_AW  register-file write address (registered)
- wb_data  out  DATA_W  register-file write data (registered)
- pend_count  out  clog2(PEND_DEPTH)+1  occupancy, used by decode for stall decisions

Behaviour:
- Reset: wb_we=0, wb_rd=0, wb_data=0, buffer empty, pend_count=0, md_ready=1.

Pipeline selection (combinational, priority order):
- Ovf-class instructions:
  - add: opcode 00000, aluop 00000; code 1.
  - sub: opcode 00000, aluop 00001; code 3.
  - addi: opcode 00101; code 2.
- setx (opcode 10101): rd=RSTATUS_REG, data=mw_target, write forced.
- Ovf-class with mw_ovf=1: rd=RSTATUS_REG, data=zero-extended code.
- jal (opcode 00011) with mw_we: rd=RA_REG, data=mw_pc_next.
- mw_load: rd=mw_rd, data=mw_dmem_q.
- Otherwise: rd=mw_rd, data=mw_alu_out.
- pipe_wr = mw_valid & (mw_we | setx) & (selected rd != 0).

Multdiv buffer:
- Circular FIFO of {rd, data}.
- md_exc=1 converts the entry on enqueue: rd=RSTATUS_REG, data=4 (mul) or 5 (div).
- Entries with rd==0 and no exception are accepted and dropped (never stored).
- md_ready = not full. A result is enqueued when md_valid & md_ready.
- Offering md_valid while md_ready=0 is a protocol violation; the block ignores it.

Arbitration (per cycle):
- pipe_wr=1: pipeline write is registered to wb_*. FIFO does not drain.
- pipe_wr=0 and FIFO non-empty: head entry is registered to wb_*. Head pops.
- Neither: wb_we=0; wb_rd and wb_data hold their previous values.

Other rules:
- Latency: exactly 1 cycle from input to wb_*.
- WAW squash: when pipe_wr=1 and its rd matches a valid buffered entry, that entry is invalidated. The newer pipeline write wins. Squashed entries still occupy a slot until they reach the head; they are then discarded with no write, taking one cycle.
- Same-cycle enqueue and pop: both occur; pend_count is unchanged.
- Enqueue while full with a simultaneous pop: not accepted, because md_ready is computed from the registered state.
- Enqueue into an empty FIFO: the entry is not visible for draining until the next cycle (no bypass).
- Pointers wrap modulo PEND_DEPTH.
- Reset mid-operation clears the buffer and wb_we within the same clock edge. Pending results are lost.

Decomposition:
- Shared package wb_pkg:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_JAL, OP_SETX
  - ALU-op constants: ALU_ADD, ALU_SUB
  - rstatus codes: 1–5
- One sub-module: wb_pend_fifo (the circular {valid, rd, data} buffer with squash-by-rd port).

Test Plan:
- add, mw_ovf=1, mw_rd=5 -> next cycle wb_we=1, wb_rd=30, wb_data=1; the same op with aluop 00001 -> wb_data=3.
- setx with target 0x0001234 and mw_we=0 -> wb_rd=30, wb_data=0x00001234; jal with pc_next=0x40 -> wb_rd=31, wb_data=0x40.
- md result (rd=7, 0xDEAD) during 3 back-to-back ALU writes -> wb_* shows the 3 ALU writes, then rd=7, 0xDEAD on the 4th idle cycle; pend_count 1 throughout, then 0.
- Fill buffer (2 md results with the pipeline busy) -> md_ready=0; one idle cycle -> pop plus md_ready=1 the following cycle.
- md result rd=9 buffered, then pipeline lw writes r9 -> the buffered entry is squashed and r9 holds the load data only; md_exc on div -> wb_rd=30, data=5.
- Writes targeting r0 from the pipeline and from md -> wb_we stays 0; assert reset with 2 entries queued -> pend_count=0, wb_we=0 next cycle.
